alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execution-side consumer of the 4-bit ALU control code from the ALU control decoder.
//  Accepts operands plus control code over a valid/ready handshake and executes the op:
//  single-cycle for logic/add/sub/move, multi-cycle iterative for MUL/MAC.
//  Holds the MAC accumulator and returns a registered result with Zero/Illegal flags
//  to writeback.
// PARAMETERS
//  WIDTH   64   operand, result and accumulator width in bits
// PORTS
//  CLK          in   1      clock; all state updates on rising edge
//  RESET        in   1      asynchronous, active-high reset
//  In_Valid     in   1      operands + ALU_Ctrl valid
//  In_Ready     out  1      unit can accept an op this cycle
//  ALU_Ctrl     in   4      control code from ALU control decoder
//  Operand_A    in   WIDTH  first operand
//  Operand_B    in   WIDTH  second operand
//  Acc_Clear    in   1      synchronous clear of MAC accumulator
//  Out_Valid    out  1      Result/Zero/Illegal valid
//  Out_Ready    in   1      writeback accepts result
//  Result       out  WIDTH  registered result
//  Zero         out  1      Result == 0, registered with Result
//  Illegal      out  1      unsupported ALU_Ctrl code, registered with Result
// BEHAVIOUR
//  Reset: state IDLE; Out_Valid, Result, Zero, Illegal, accumulator, iteration counter = 0.
//  Reset mid-MUL aborts the op; no result is produced.
//  FSM: IDLE -> (accept MUL/MAC) -> MUL -> (counter == WIDTH-1) -> IDLE with result.
//   In_Ready = (state == IDLE) && (!Out_Valid || Out_Ready); accept = In_Valid && In_Ready.
//  Op codes (all arithmetic modulo 2^WIDTH, no carry/overflow outputs):
//   0000 AND  A & B       0001 ORR  A | B       0010 ADD  A + B
//   0110 SUB  A - B       0101 MOV  B           0111 PASSB B (compare-to-zero branch)
//   0100 MUL  low WIDTH bits of A*B
//   1000 MAC  acc <= acc + A*B (low bits); Result = new acc
//   any other code: Result = 0, Illegal = 1, latency 1 cycle
//  Latency: single-cycle ops -> Out_Valid the cycle after accept.
//   MUL/MAC iterative shift-add, 1 multiplier bit/cycle: Out_Valid WIDTH+1 cycles after accept.
//  Output hold: Result/Zero/Illegal stable while Out_Valid && !Out_Ready;
//   Out_Valid drops the cycle after Out_Ready unless a new op completes on that edge.
//  Back-to-back: single-cycle ops sustain 1 op/cycle while Out_Ready = 1.
//  In_Ready = 0 throughout the MUL state; In_Valid is ignored there.
//  Acc_Clear: accumulator <= 0 on the next edge.
//   If Acc_Clear coincides with MAC completion, the clear applies first: acc <= A*B.
//   Acc_Clear never affects Result or Out_Valid.
//  Operands and code are captured at accept; input changes during MUL have no effect.
//  X/Z on ALU_Ctrl at accept is treated as an unsupported code (Illegal = 1).
// CONFIGURATION
//  ALU_MUL_FAST_EN defined: MUL/MAC use a single-cycle combinational multiplier.
//   Latency is 1, MUL state and counter are removed, and In_Ready depends only on output backpressure.
//  ALU_MUL_FAST_EN undefined: iterative multiplier as above (WIDTH+1 cycle latency).
//  Results are bit-identical in both builds.
// TESTING
//  1 ADD A=5,B=7 -> next cycle Out_Valid=1, Result=12, Zero=0.
//    SUB A=3,B=3 -> Result=0, Zero=1.
//  2 SUB A=0,B=1 -> Result=all ones (wrap).
//    Code 1111 -> Result=0, Illegal=1, latency 1.
//  3 MUL A=6,B=7 -> In_Ready=0 for WIDTH cycles, Out_Valid at cycle WIDTH+1, Result=42.
//    With ALU_MUL_FAST_EN: latency 1.
//  4 Acc_Clear, then MAC(3,4), MAC(2,5) -> Results 12 then 22.
//    MAC(1,1) with Acc_Clear on its completion cycle -> Result=1, acc=1.
//  5 Hold Out_Ready=0 after ADD 1+1 -> Result=2 held, In_Ready=0.
//    Release -> next op accepted the same cycle.
//  6 Assert RESET midway through MUL -> all outputs 0 and state IDLE.
//    A following ADD 2+2 returns 4 with normal latency.

Source files
------------

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_exec_unit                                                |
// | Description : ALU execution unit with valid/ready handshakes, an iterative |
// |               shift-add MUL/MAC and a MAC accumulator. Defining            |
// |               ALU_MUL_FAST_EN swaps in a single-cycle multiplier.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_exec_unit #(
    parameter int WIDTH = 64
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [3:0]       ALU_Ctrl,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    input  logic             Acc_Clear,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Illegal
);

    localparam logic [3:0] c_op_and   = 4'b0000;
    localparam logic [3:0] c_op_orr   = 4'b0001;
    localparam logic [3:0] c_op_add   = 4'b0010;
    localparam logic [3:0] c_op_mul   = 4'b0100;
    localparam logic [3:0] c_op_mov   = 4'b0101;
    localparam logic [3:0] c_op_sub   = 4'b0110;
    localparam logic [3:0] c_op_passb = 4'b0111;
    localparam logic [3:0] c_op_mac   = 4'b1000;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_mac;
    logic             w_illegal;
    logic [WIDTH-1:0] w_simple;
    logic [WIDTH-1:0] w_product;
    logic [WIDTH-1:0] w_mac_new;
    logic             w_done;
    logic             w_done_mac;
    logic             w_done_illegal;
    logic [WIDTH-1:0] w_done_result;
    logic [WIDTH-1:0] r_acc;

    // Unknown or X codes fall into the default arm and are flagged illegal.
    always_comb begin
        w_is_mul  = 1'b0;
        w_is_mac  = 1'b0;
        w_illegal = 1'b0;
        w_simple  = {WIDTH{1'b0}};
        case (ALU_Ctrl)
            c_op_and:   w_simple = Operand_A & Operand_B;
            c_op_orr:   w_simple = Operand_A | Operand_B;
            c_op_add:   w_simple = Operand_A + Operand_B;
            c_op_sub:   w_simple = Operand_A - Operand_B;
            c_op_mov:   w_simple = Operand_B;
            c_op_passb: w_simple = Operand_B;
            c_op_mul:   w_is_mul = 1'b1;
            c_op_mac: begin
                w_is_mul = 1'b1;
                w_is_mac = 1'b1;
            end
            default:    w_illegal = 1'b1;
        endcase
    end

    // A clear landing on the MAC completion edge zeroes the old value first.
    assign w_mac_new = (Acc_Clear ? {WIDTH{1'b0}} : r_acc) + w_product;

`ifdef ALU_MUL_FAST_EN

    assign In_Ready       = !Out_Valid || Out_Ready;
    assign w_accept       = In_Valid && In_Ready;
    assign w_product      = Operand_A * Operand_B;
    assign w_done         = w_accept;
    assign w_done_mac     = w_accept && w_is_mac;
    assign w_done_illegal = w_illegal;
    assign w_done_result  = w_is_mul ? (w_is_mac ? w_mac_new : w_product) : w_simple;

`else

    localparam int         CW         = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);
    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_MUL      = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_prod;
    logic             r_mac_op;
    logic [WIDTH-1:0] w_prod_step;
    logic             w_mul_last;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:   if (r_cnt == c_cnt_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        In_Ready = (r_state == S_IDLE) && (!Out_Valid || Out_Ready);
    end

    assign w_accept    = In_Valid && In_Ready;
    assign w_mul_last  = (r_state == S_MUL) && (r_cnt == c_cnt_last);
    assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});
    assign w_product   = w_prod_step;

    // One multiplier bit per cycle; the last step's sum is the full product.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt    <= {CW{1'b0}};
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_prod   <= {WIDTH{1'b0}};
            r_mac_op <= 1'b0;
        end else if (w_accept && w_is_mul) begin
            r_cnt    <= {CW{1'b0}};
            r_mcand  <= Operand_A;
            r_mplier <= Operand_B;
            r_prod   <= {WIDTH{1'b0}};
            r_mac_op <= w_is_mac;
        end else if (r_state == S_MUL) begin
            r_cnt    <= r_cnt + CW'(1);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_prod   <= w_prod_step;
        end
    end

    assign w_done         = (w_accept && !w_is_mul) || w_mul_last;
    assign w_done_mac     = w_mul_last && r_mac_op;
    assign w_done_illegal = w_mul_last ? 1'b0 : w_illegal;
    assign w_done_result  = w_mul_last ? (r_mac_op ? w_mac_new : w_product) : w_simple;

`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Out_Valid <= 1'b0;
            Result    <= {WIDTH{1'b0}};
            Zero      <= 1'b0;
            Illegal   <= 1'b0;
            r_acc     <= {WIDTH{1'b0}};
        end else begin
            if (w_done) begin
                Out_Valid <= 1'b1;
                Result    <= w_done_result;
                Zero      <= (w_done_result == {WIDTH{1'b0}});
                Illegal   <= w_done_illegal;
            end else if (Out_Ready) begin
                Out_Valid <= 1'b0;
            end
            if (w_done_mac) begin
                r_acc <= w_mac_new;
            end else if (Acc_Clear) begin
                r_acc <= {WIDTH{1'b0}};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_exec_unit                                             |
// | Description : Scoreboard bench for alu_exec_unit; honours ALU_MUL_FAST_EN. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_exec_unit;

    localparam int W = 64;
`ifdef ALU_MUL_FAST_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         In_Valid = 1'b0;
    logic         In_Ready;
    logic [3:0]   ALU_Ctrl = 4'b0;
    logic [W-1:0] Operand_A = '0;
    logic [W-1:0] Operand_B = '0;
    logic         Acc_Clear = 1'b0;
    logic         Out_Valid;
    logic         Out_Ready = 1'b0;
    logic [W-1:0] Result;
    logic         Zero;
    logic         Illegal;

    alu_exec_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .ALU_Ctrl(ALU_Ctrl), .Operand_A(Operand_A), .Operand_B(Operand_B),
        .Acc_Clear(Acc_Clear), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Result(Result), .Zero(Zero), .Illegal(Illegal)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit rand_mode = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           done_cyc;
    } op_t;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ill;
        int           at_cyc;
    } exp_t;

    op_t          pend[$];
    exp_t         sb[$];
    logic [W-1:0] m_acc = '0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input logic [3:0] op);
        return (op == 4'b0100 || op == 4'b1000) ? MUL_LAT : 1;
    endfunction

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Reference model: records accepted ops and computes each result in its completion cycle.
    always @(negedge CLK) begin
        op_t  o;
        exp_t e;
        bit   mac_done;
        mac_done = 0;
        if (RESET) begin
            pend.delete();
            sb.delete();
            m_acc = '0;
        end else begin
            if (In_Valid && In_Ready) begin
                o.op = ALU_Ctrl;
                o.a = Operand_A;
                o.b = Operand_B;
                o.done_cyc = cyc + lat_of(ALU_Ctrl) - 1;
                pend.push_back(o);
            end
            while (pend.size() > 0 && pend[0].done_cyc == cyc) begin
                o = pend.pop_front();
                e.ill = 0;
                case (o.op)
                    4'b0000: e.res = o.a & o.b;
                    4'b0001: e.res = o.a | o.b;
                    4'b0010: e.res = o.a + o.b;
                    4'b0110: e.res = o.a - o.b;
                    4'b0101, 4'b0111: e.res = o.b;
                    4'b0100: e.res = o.a * o.b;
                    4'b1000: begin
                        m_acc = (Acc_Clear ? '0 : m_acc) + o.a * o.b;
                        e.res = m_acc;
                        mac_done = 1;
                    end
                    default: begin
                        e.res = '0;
                        e.ill = 1;
                    end
                endcase
                e.zero = (e.res == '0);
                e.at_cyc = cyc + 1;
                sb.push_back(e);
            end
            if (Acc_Clear && !mac_done) m_acc = '0;
        end
    end

    // Monitor: pairs each freshly presented result with the scoreboard head, then watches the hold.
    bit   prev_pending = 0;
    exp_t cur;
    always @(negedge CLK) begin
        if (RESET) begin
            prev_pending = 0;
        end else if (Out_Valid) begin
            if (!prev_pending) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1'b1, 1'b0);
                end else begin
                    cur = sb.pop_front();
                    chk("result", Result, cur.res);
                    chk("zero", Zero, cur.zero);
                    chk("illegal", Illegal, cur.ill);
                    chk("latency", W'(cyc), W'(cur.at_cyc));
                end
            end else begin
                chk("hold_result", Result, cur.res);
                chk("hold_flags", {Zero, Illegal}, {cur.zero, cur.ill});
            end
            prev_pending = !Out_Ready;
        end else begin
            if (prev_pending) chk("valid_dropped", 1'b0, 1'b1);
            if (sb.size() > 0 && sb[0].at_cyc <= cyc) begin
                chk("missing_result", 1'b0, 1'b1);
                void'(sb.pop_front());
            end
            prev_pending = 0;
        end
    end

    always @(posedge CLK) begin
        if (rand_mode) begin
            #1;
            Out_Ready = ($urandom_range(0, 3) != 0);
            Acc_Clear = ($urandom_range(0, 7) == 0);
        end
    end

    // Drives one op from the post-edge phase and returns in the cycle after acceptance.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit clr, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        ALU_Ctrl = op;
        Operand_A = a;
        Operand_B = b;
        In_Valid = 1;
        if (clr) Acc_Clear = 1;
        while (!ok && waited < 400) begin
            @(negedge CLK);
            ok = In_Ready;
            @(posedge CLK);
            #1;
            waited++;
        end
        In_Valid = 0;
        if (clr) Acc_Clear = 0;
        ALU_Ctrl = 4'($urandom);
        Operand_A = rnd();
        Operand_B = rnd();
        if (!ok) chk("issue_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_chk(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit clr_done,
                           input logic [W-1:0] res, input logic zero, input logic ill);
        int lat;
        int w;
        lat = lat_of(op);
        issue(op, a, b, clr_done && lat == 1, w);
        if (lat > 1) begin
            repeat (lat - 2) begin
                @(posedge CLK);
                #1;
            end
            if (clr_done) Acc_Clear = 1;
            @(posedge CLK);
            #1;
            Acc_Clear = 0;
        end
        @(negedge CLK);
        chk({nm, "_valid"}, Out_Valid, 1'b1);
        chk({nm, "_result"}, Result, res);
        chk({nm, "_zero"}, Zero, zero);
        chk({nm, "_illegal"}, Illegal, ill);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int w;
        int lowcnt;
        logic [3:0] op;

        repeat (2) @(negedge CLK);
        chk("rst_outputs", {Out_Valid, Zero, Illegal}, 3'b000);
        chk("rst_result", Result, '0);
        chk("rst_in_ready", In_Ready, 1'b1);
        @(posedge CLK);
        #1;
        RESET = 0;
        Out_Ready = 1;
        @(posedge CLK);
        #1;

        run_chk("add", 4'b0010, 5, 7, 0, 12, 0, 0);
        run_chk("sub_eq", 4'b0110, 3, 3, 0, 0, 1, 0);
        run_chk("sub_wrap", 4'b0110, 0, 1, 0, '1, 0, 0);
        run_chk("code_f", 4'b1111, 9, 9, 0, 0, 1, 1);
        run_chk("and", 4'b0000, 64'hF0F0, 64'h3C3C, 0, 64'h3030, 0, 0);
        run_chk("orr", 4'b0001, 64'hF000, 64'h000F, 0, 64'hF00F, 0, 0);
        run_chk("mov", 4'b0101, 64'h1234, 64'h55, 0, 64'h55, 0, 0);
        run_chk("passb", 4'b0111, 64'h77, 0, 0, 0, 1, 0);

        issue(4'b0100, 6, 7, 0, w);
`ifndef ALU_MUL_FAST_EN
        lowcnt = 0;
        repeat (W) begin
            @(negedge CLK);
            if (!In_Ready && !Out_Valid) lowcnt++;
        end
        chk("mul_busy_cycles", W'(lowcnt), W'(W));
`endif
        @(negedge CLK);
        chk("mul_valid", Out_Valid, 1'b1);
        chk("mul_result", Result, 42);
        @(posedge CLK);
        #1;

        Acc_Clear = 1;
        @(posedge CLK);
        #1;
        Acc_Clear = 0;
        run_chk("mac1", 4'b1000, 3, 4, 0, 12, 0, 0);
        run_chk("mac2", 4'b1000, 2, 5, 0, 22, 0, 0);
        run_chk("mac_clr_done", 4'b1000, 1, 1, 1, 1, 0, 0);
        run_chk("mac_acc_after", 4'b1000, 0, 0, 0, 1, 0, 0);

        Out_Ready = 0;
        issue(4'b0010, 1, 1, 0, w);
        repeat (3) begin
            @(negedge CLK);
            chk("bp_valid", Out_Valid, 1'b1);
            chk("bp_result", Result, 2);
            chk("bp_in_ready", In_Ready, 1'b0);
            @(posedge CLK);
            #1;
        end
        Out_Ready = 1;
        issue(4'b0010, 3, 4, 0, w);
        chk("release_accept_wait", W'(w), 1);
        @(negedge CLK);
        chk("release_result", Result, 7);
        @(posedge CLK);
        #1;

        issue(4'b0100, rnd(), rnd(), 0, w);
        repeat (W / 2) begin
            @(posedge CLK);
            #1;
        end
        RESET = 1;
        #1;
        chk("midrst_outputs", {Out_Valid, Zero, Illegal}, 3'b000);
        chk("midrst_result", Result, '0);
        chk("midrst_idle", In_Ready, 1'b1);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 0;
        run_chk("post_rst_add", 4'b0010, 2, 2, 0, 4, 0, 0);
        run_chk("post_rst_mac", 4'b1000, 1, 2, 0, 2, 0, 0);

        for (int i = 0; i < 8; i++) begin
            issue(4'($urandom_range(0, 2)), rnd(), rnd(), 0, w);
            chk("b2b_accept_wait", W'(w), 1);
        end

        rand_mode = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0: op = 4'b0000;
                1: op = 4'b0001;
                2: op = 4'b0010;
                3: op = 4'b0110;
                4: op = 4'b0101;
                5: op = 4'b0111;
                6: op = 4'b0100;
                7: op = 4'b1000;
                8: op = 4'b0011;
                default: op = 4'($urandom_range(9, 15));
            endcase
            issue(op, rnd(), rnd(), 0, w);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK);
                #1;
            end
        end
        rand_mode = 0;
        @(posedge CLK);
        #2;
        Out_Ready = 1;
        Acc_Clear = 0;

        w = 0;
        while ((sb.size() > 0 || pend.size() > 0 || Out_Valid) && w < 400) begin
            @(posedge CLK);
            #1;
            w++;
        end
        if (w >= 400) chk("drain_timeout", 1'b0, 1'b1);
        repeat (2) @(posedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
